// File: rtl/beep_pattern_gen.sv
// Programmable buzzer driver: timed ON/OFF bursts with optional tone carrier.
// state | meaning: S_IDLE = silent, waiting for start | S_ON = beep phase | S_OFF = gap between bursts
module beep_pattern_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int DUR_W   = 16,
    parameter int TONE_W  = 16
) (
    input  logic              sys_clk_i,
    input  logic              ext_rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [DUR_W-1:0]  on_ticks,
    input  logic [DUR_W-1:0]  off_ticks,
    input  logic [7:0]        repeat_n,
    input  logic [TONE_W-1:0] tone_half,
    output logic              busy,
    output logic              done,
    output logic              beep
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    state_t            state;
    logic [PW-1:0]     presc;
    logic [DUR_W-1:0]  tick;
    logic [TONE_W-1:0] tone_cnt;
    logic [7:0]        burst;
    logic [DUR_W-1:0]  on_l;
    logic [DUR_W-1:0]  off_l;
    logic [7:0]        rep_l;
    logic [TONE_W-1:0] tone_l;

    logic       tick_end;
    logic       on_last;
    logic       off_last;
    logic       last_burst;
    logic       tone_flip;
    logic [7:0] burst_next;

    assign tick_end   = (presc == PRE_LAST);
    assign on_last    = tick_end && (tick == on_l - DUR_W'(1));
    assign off_last   = tick_end && (tick == off_l - DUR_W'(1));
    assign last_burst = (rep_l != 8'd0) && (burst == rep_l);
    assign tone_flip  = (tone_cnt == tone_l - TONE_W'(1));
    // Saturates so continuous mode can run forever without wrapping.
    assign burst_next = (burst == 8'hFF) ? burst : burst + 8'd1;

    always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state    <= S_IDLE;
            presc    <= '0;
            tick     <= '0;
            tone_cnt <= '0;
            burst    <= '0;
            on_l     <= '0;
            off_l    <= '0;
            rep_l    <= '0;
            tone_l   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            beep     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                beep     <= 1'b0;
                presc    <= '0;
                tick     <= '0;
                tone_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && (on_ticks != '0)) begin
                            on_l     <= on_ticks;
                            off_l    <= off_ticks;
                            rep_l    <= repeat_n;
                            tone_l   <= tone_half;
                            state    <= S_ON;
                            busy     <= 1'b1;
                            beep     <= 1'b1;
                            presc    <= '0;
                            tick     <= '0;
                            tone_cnt <= '0;
                            burst    <= 8'd1;
                        end
                    end
                    S_ON: begin
                        if (on_last) begin
                            presc    <= '0;
                            tick     <= '0;
                            tone_cnt <= '0;
                            if (last_burst) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                beep  <= 1'b0;
                                done  <= 1'b1;
                            end else if (off_l == '0) begin
                                beep  <= 1'b1;
                                burst <= burst_next;
                            end else begin
                                state <= S_OFF;
                                beep  <= 1'b0;
                            end
                        end else begin
                            if (tick_end) begin
                                presc <= '0;
                                tick  <= tick + DUR_W'(1);
                            end else begin
                                presc <= presc + PW'(1);
                            end
                            if (tone_l != '0) begin
                                if (tone_flip) begin
                                    tone_cnt <= '0;
                                    beep     <= ~beep;
                                end else begin
                                    tone_cnt <= tone_cnt + TONE_W'(1);
                                end
                            end
                        end
                    end
                    S_OFF: begin
                        if (off_last) begin
                            presc <= '0;
                            tick  <= '0;
                            state <= S_ON;
                            beep  <= 1'b1;
                            burst <= burst_next;
                        end else if (tick_end) begin
                            presc <= '0;
                            tick  <= tick + DUR_W'(1);
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        beep  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Bench for beep_pattern_gen: elapsed-time reference model, directed scenarios and random traffic.
module tb_beep_pattern_gen;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] on_ticks = '0;
    logic [15:0] off_ticks = '0;
    logic [7:0]  repeat_n = '0;
    logic [15:0] tone_half = '0;
    logic        busy;
    logic        done;
    logic        beep;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    beep_pattern_gen #(
        .CLK_HZ(1000), .TICK_HZ(100), .DUR_W(16), .TONE_W(16)
    ) dut (
        .sys_clk_i(clk), .ext_rst_n(rst_n), .start(start), .stop(stop),
        .on_ticks(on_ticks), .off_ticks(off_ticks), .repeat_n(repeat_n),
        .tone_half(tone_half), .busy(busy), .done(done), .beep(beep)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a pattern is described purely by elapsed cycles j since the accepting edge.
    function automatic longint period(input longint on, input longint off);
        return (on + off) * DIV;
    endfunction

    function automatic longint pat_len(input longint on, input longint off, input longint rep);
        return (rep - 1) * period(on, off) + on * DIV;
    endfunction

    function automatic longint beep_at(input longint j, input longint on, input longint off,
                                       input longint tone);
        longint o;
        o = (j - 1) % period(on, off);
        if (o >= on * DIV) return 0;
        if (tone == 0) return 1;
        return ((o / tone) % 2 == 0) ? 1 : 0;
    endfunction

    bit     m_busy, m_done;
    longint m_j, m_on, m_off, m_rep, m_tone;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_j    <= 0;
        end else begin
            m_done <= 1'b0;
            if (stop) begin
                m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (start && on_ticks != 0) begin
                    m_busy <= 1'b1;
                    m_j    <= 1;
                    m_on   <= longint'(on_ticks);
                    m_off  <= longint'(off_ticks);
                    m_rep  <= longint'(repeat_n);
                    m_tone <= longint'(tone_half);
                end
            end else if (m_rep != 0 && m_j == pat_len(m_on, m_off, m_rep)) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_j <= m_j + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("model_beep", beep, m_busy ? beep_at(m_j, m_on, m_off, m_tone) : 0);
            chk("model_busy", busy, m_busy);
            chk("model_done", done, m_done);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input int on, input int off, input int rep, input int tone);
        on_ticks  = 16'(on);
        off_ticks = 16'(off);
        repeat_n  = 8'(rep);
        tone_half = 16'(tone);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // 30 high, 20 low, 30 high, done in cycle 81.
    task automatic run_steady(input string tag);
        int n_busy, n_done, done_at, beep_err;
        logic exp_b;
        n_busy = 0; n_done = 0; done_at = 0; beep_err = 0;
        do_start(3, 2, 2, 0);
        for (int c = 1; c <= 85; c++) begin
            exp_b = ((c >= 1 && c <= 30) || (c >= 51 && c <= 80));
            if (beep !== exp_b) beep_err++;
            if (busy) n_busy++;
            if (done) begin n_done++; done_at = c; end
            tick();
        end
        chk({tag, "_beep_shape"}, beep_err, 0);
        chk({tag, "_busy_len"}, n_busy, 80);
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_done_at"}, done_at, 81);
    endtask

    initial begin
        logic [10:0] tone_exp;
        logic [10:0] tone_act;
        int n, dn;

        repeat (2) tick();
        chk("reset_beep", beep, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (3) tick();

        run_steady("steady");
        repeat (3) tick();

        tone_exp = 11'b01100110011;
        tone_act = '0;
        dn = 0;
        do_start(1, 0, 1, 2);
        for (int c = 1; c <= 11; c++) begin
            tone_act[c-1] = beep;
            if (done) dn = c;
            tick();
        end
        chk("tone_seq", tone_act, tone_exp);
        chk("tone_done_at", dn, 11);
        repeat (3) tick();

        n = 0;
        do_start(1, 1, 0, 0);
        for (int c = 1; c <= 149; c++) begin
            if (done) n++;
            tick();
        end
        chk("cont_mid_on_beep", beep, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("cont_stop_beep", beep, 0);
        chk("cont_stop_busy", busy, 0);
        repeat (5) begin
            if (done) n++;
            tick();
        end
        chk("cont_no_done", n, 0);

        n = 0; dn = 0;
        do_start(2, 0, 3, 0);
        for (int c = 1; c <= 62; c++) begin
            if (c <= 60 && beep) n++;
            if (done) dn = c;
            tick();
        end
        chk("merge_high_cycles", n, 60);
        chk("merge_done_at", dn, 61);
        repeat (3) tick();

        do_start(3, 2, 2, 0);
        repeat (5) tick();
        on_ticks = 16'd1; off_ticks = 16'd0; repeat_n = 8'd1; tone_half = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int c = 7; c <= 90; c++) begin
            if (busy) n++;
            tick();
        end
        chk("busy_start_ignored", n, 74);

        on_ticks = 16'd2;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", busy, 0);
        tick();
        chk("start_stop_idle2", busy, 0);

        on_ticks = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_on_ignored", busy, 0);
        repeat (2) tick();

        do_start(1, 0, 1, 0);
        repeat (10) tick();
        chk("b2b_done", done, 1);
        chk("b2b_busy_low", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_beep", beep, 1);
        repeat (12) tick();

        do_start(3, 2, 2, 0);
        repeat (10) tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_beep", beep, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_done", done, 0);
        tick();
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            chk("post_rst_idle", busy, 0);
        end
        run_steady("post_rst");
        repeat (3) tick();

        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 5) == 0);
            stop      = ($urandom_range(0, 59) == 0);
            on_ticks  = 16'($urandom_range(0, 3));
            off_ticks = 16'($urandom_range(0, 3));
            repeat_n  = 8'($urandom_range(0, 3));
            tone_half = 16'($urandom_range(0, 4));
            tick();
        end
        start = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("final_idle", busy, 0);
        tick();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
